data_sampling_mv: RTL and testbench
===================================

Name: data_sampling_mv

Overview:
- Parametrised successor to the UART RX single-mode sampler: majority-vote bit recovery with a selectable vote count (1/3/5 samples) and oversampling prescale 4/8/16/32.
- Per-bit configuration latch; registered decision strobe; noise flag raised when the votes are not unanimous.
- Sits between the RX edge/bit counter and the RX FSM / deserializer.

Parameters:
- CNT_W, 5, width of edge_cnt; supports prescale up to 2^CNT_W.
- PRE_W, 6, width of the prescale input; must be CNT_W+1.

Ports:
- clk  input  1  RX oversampling clock.
- rst  input  1  asynchronous, active-low reset.
- prescale  input  PRE_W  oversampling ratio; legal values 4, 8, 16, 32.
- samp_mode  input  2  vote count: 0 = 1 sample, 1 = 3 samples, 2 = 5 samples, 3 = treated as 3.
- rx_in  input  1  serial input, already synchronised to clk.
- data_samp_en  input  1  sampling enable from the RX FSM.
- edge_cnt  input  CNT_W  edge position within the current bit, 0..prescale-1.
- sampled_bit  output  1  voted bit value (registered).
- sampled_valid  output  1  one-cycle pulse when sampled_bit is updated.
- noise_flag  output  1  votes for the last decided bit were not unanimous; valid with sampled_valid, held until the next decision.

Behaviour:
- Reset (rst=0, async):
  - sampled_bit=1, sampled_valid=0, noise_flag=0.
  - Accumulators cleared; bit_active=0.
  - Latched config = prescale 8, N=3.
- Config latch: on a clock where data_samp_en=1 and edge_cnt==0:
  - prescale is latched as P, and N is derived from samp_mode.
  - bit_active is set to 1.
  - The accumulators are cleared in the same cycle, and this edge's sample is not lost (edge 0 is never a sample point).
- N clamping:
  - If P==4 and N==5, use N=3.
  - If P is not in {4, 8, 16, 32}, bit_active stays 0 and no decision is made for that bit.
- Sample window:
  - C = P/2.
  - Samples are taken at edge_cnt in C-(N-1)/2 .. C+(N-1)/2, inclusive.
  - Examples: P=8, N=3 -> 3, 4, 5. P=16, N=5 -> 6..10. P=4, N=1 -> 2.
- Accumulators: ones_cnt (3 bits) and samp_cnt (3 bits). Each sample cycle increments samp_cnt, and increments ones_cnt if rx_in=1.
- Decision: on a clock with data_samp_en=1, edge_cnt==P-1 and bit_active=1:
  - sampled_bit <= (2*ones_cnt > samp_cnt).
  - noise_flag <= (ones_cnt != 0 && ones_cnt != samp_cnt).
  - sampled_valid <= 1 for exactly one cycle.
  - Accumulators cleared; bit_active cleared.
  - Latency: the outputs are visible the cycle after the edge_cnt==P-1 clock.
- Incomplete bit: if samp_cnt < N at decision time (enable asserted late in the bit), the decision is still made on the samples taken. If samp_cnt==0, hold sampled_bit, set noise_flag=1 and still pulse valid.
- Late enable: if data_samp_en rises with edge_cnt != 0, bit_active=0 and no sampling or decision happens until the next edge_cnt==0.
- Enable drop: data_samp_en=0 clears the accumulators and bit_active. sampled_bit and noise_flag hold; sampled_valid=0.
- Mid-bit config change: changes to prescale or samp_mode while bit_active=1 are ignored until the next latch.
- sampled_valid is 0 on every cycle not described above.

Decomposition:
- Package uart_rx_pkg:
  - samp_mode encodings (SAMP_1, SAMP_3, SAMP_5).
  - Legal prescale constants (PRE_4, PRE_8, PRE_16, PRE_32).
  - Reset defaults (DEF_PRESCALE=8, DEF_N=3).
- Optional sub-module majority_vote: combinational.
  - Inputs: ones_cnt, samp_cnt.
  - Outputs: bit, noise.
  - Kept separate so the RX parity/stop checker can reuse it.
- Config latch, window compare and accumulators stay in the top module.

Test Plan:
- P=8, mode=1, rx_in=1 at edges 3, 4, 5 -> sampled_bit=1, noise_flag=0, one valid pulse one cycle after edge 7.
- P=16, mode=2, rx_in=0 at edges 6 and 10, 1 at edges 7, 8, 9 -> sampled_bit=1, noise_flag=1.
- P=4, mode=2 (clamped to N=3), rx_in pattern 0, 0, 1 at edges 1, 2, 3 -> sampled_bit=0, noise_flag=1, no decision window error.
- P=32, mode=0, rx_in=0 only at edge 16 -> sampled_bit=0, noise_flag=0. Then change prescale to 8 at edge 20 -> current bit still decided at edge 31.
- Enable rises at edge_cnt=5 (P=8) -> no valid for that bit; next bit starting at edge 0 decides normally. Enable dropped at edge 4 -> no valid, outputs hold.
- Async reset asserted at edge 4 mid-bit -> sampled_bit=1, valid=0, noise=0 immediately; illegal P=12 -> no valid pulses for any bit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX sampling path: vote-count encodings,
// legal oversampling ratios, reset defaults and configuration helpers.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    SAMP_1     = 2'd0,
    SAMP_3     = 2'd1,
    SAMP_5     = 2'd2,
    SAMP_3_ALT = 2'd3
  } samp_mode_e;

  localparam int PRE_4  = 4;
  localparam int PRE_8  = 8;
  localparam int PRE_16 = 16;
  localparam int PRE_32 = 32;

  // Vote accumulators hold at most 5 samples.
  localparam int ACC_W = 3;

  localparam int               DEF_PRESCALE = PRE_8;
  localparam logic [ACC_W-1:0] DEF_N        = 3'd3;

  // Number of votes for a bit; a 5-sample window does not fit in a 4x bit,
  // so it falls back to 3 samples there.
  function automatic logic [ACC_W-1:0] votes_for(input logic [1:0] mode, input int pre);
    logic [ACC_W-1:0] n;
    case (samp_mode_e'(mode))
      SAMP_1:  n = 3'd1;
      SAMP_5:  n = (pre == PRE_4) ? 3'd3 : 3'd5;
      default: n = 3'd3;
    endcase
    return n;
  endfunction

  function automatic logic pre_legal(input int pre);
    return (pre == PRE_4) || (pre == PRE_8) || (pre == PRE_16) || (pre == PRE_32);
  endfunction

endpackage

// File: rtl/majority_vote.sv
// Combinational majority decision over accumulated samples; also used by the
// RX parity/stop checker.
module majority_vote
  import uart_rx_pkg::*;
(
  input  logic [ACC_W-1:0] ones_cnt,
  input  logic [ACC_W-1:0] samp_cnt,
  output logic             voted_bit,
  output logic             noise
);

  // Strict majority: more ones than zeros among the samples taken.
  assign voted_bit = ({ones_cnt, 1'b0} > {1'b0, samp_cnt});
  // Anything other than all-zero or all-one votes counts as noise.
  assign noise     = (ones_cnt != '0) && (ones_cnt != samp_cnt);

endmodule

// File: rtl/data_sampling_mv.sv
// UART RX majority-vote sampler: latches prescale and vote count at the start
// of each bit, accumulates votes inside a window centred on the bit, and
// emits a registered decision strobe at the last edge of the bit.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic [1:0]       samp_mode,
  input  logic             rx_in,
  input  logic             data_samp_en,
  input  logic [CNT_W-1:0] edge_cnt,
  output logic             sampled_bit,
  output logic             sampled_valid,
  output logic             noise_flag
);

  logic [PRE_W-1:0] p_lat;
  logic [ACC_W-1:0] n_lat;
  logic             bit_active;

  logic [ACC_W-1:0] ones_cnt;
  logic [ACC_W-1:0] samp_cnt;
  logic [ACC_W-1:0] ones_nxt;
  logic [ACC_W-1:0] samp_nxt;
  logic [ACC_W-1:0] half_span;

  logic [PRE_W-1:0] edge_w;
  logic [PRE_W-1:0] centre;
  logic [PRE_W-1:0] span_w;
  logic [PRE_W-1:0] win_lo;
  logic [PRE_W-1:0] win_hi;
  logic [PRE_W-1:0] last_edge;

  logic             latch_cfg;
  logic             samp_hit;
  logic             decide;
  logic             vote_bit;
  logic             vote_noise;

  assign latch_cfg = data_samp_en && (edge_cnt == '0);

  // Window is centred on P/2 and spans (N-1)/2 edges either side.
  assign edge_w    = PRE_W'(edge_cnt);
  assign centre    = p_lat >> 1;
  assign half_span = (n_lat - ACC_W'(1)) >> 1;
  assign span_w    = PRE_W'(half_span);
  assign win_lo    = centre - span_w;
  assign win_hi    = centre + span_w;
  assign last_edge = p_lat - PRE_W'(1);

  assign samp_hit = data_samp_en && bit_active && !latch_cfg &&
                    (edge_w >= win_lo) && (edge_w <= win_hi);
  assign decide   = data_samp_en && bit_active && !latch_cfg && (edge_w == last_edge);

  // For P=4 the last window edge is also the decision edge, so the vote
  // looks at the counts including this cycle's sample.
  assign ones_nxt = ones_cnt + ACC_W'(samp_hit && rx_in);
  assign samp_nxt = samp_cnt + ACC_W'(samp_hit);

  majority_vote u_vote (
    .ones_cnt  (ones_nxt),
    .samp_cnt  (samp_nxt),
    .voted_bit (vote_bit),
    .noise     (vote_noise)
  );

  // Per-bit configuration latch and bit-in-progress flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_lat      <= PRE_W'(DEF_PRESCALE);
      n_lat      <= DEF_N;
      bit_active <= 1'b0;
    end else if (!data_samp_en) begin
      bit_active <= 1'b0;
    end else if (latch_cfg) begin
      p_lat      <= prescale;
      n_lat      <= votes_for(samp_mode, int'(prescale));
      bit_active <= pre_legal(int'(prescale));
    end else if (decide) begin
      bit_active <= 1'b0;
    end
  end

  // Vote accumulators: cleared at bit start, decision and enable drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt <= '0;
      samp_cnt <= '0;
    end else if (!data_samp_en || latch_cfg || decide) begin
      ones_cnt <= '0;
      samp_cnt <= '0;
    end else if (samp_hit) begin
      ones_cnt <= ones_nxt;
      samp_cnt <= samp_nxt;
    end
  end

  // Registered decision: strobe for one cycle, bit and noise held until next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampled_bit   <= 1'b1;
      sampled_valid <= 1'b0;
      noise_flag    <= 1'b0;
    end else begin
      sampled_valid <= decide;
      if (decide) begin
        if (samp_nxt == '0) begin
          noise_flag <= 1'b1;
        end else begin
          sampled_bit <= vote_bit;
          noise_flag  <= vote_noise;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sampling_mv.sv
// Scoreboard bench for data_sampling_mv: each bit pushes its expected
// decision (value, noise, strobe cycle) and a monitor pops on every strobe.
module tb_data_sampling_mv;

  logic       clk;
  logic       rst;
  logic [5:0] prescale;
  logic [1:0] samp_mode;
  logic       rx_in;
  logic       data_samp_en;
  logic [4:0] edge_cnt;
  logic       sampled_bit;
  logic       sampled_valid;
  logic       noise_flag;

  typedef struct {
    logic b;
    logic n;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  data_sampling_mv #(.CNT_W(5), .PRE_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .prescale      (prescale),
    .samp_mode     (samp_mode),
    .rx_in         (rx_in),
    .data_samp_en  (data_samp_en),
    .edge_cnt      (edge_cnt),
    .sampled_bit   (sampled_bit),
    .sampled_valid (sampled_valid),
    .noise_flag    (noise_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && sampled_valid !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: valid=%b bit=%b noise=%b at cyc %0d, required no strobe",
                 sampled_valid, sampled_bit, noise_flag, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (sampled_bit !== e.b || noise_flag !== e.n || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL decision: bit=%b noise=%b cyc=%0d, required bit=%b noise=%b cyc=%0d",
                   sampled_bit, noise_flag, cyc, e.b, e.n, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one bit period; enable is high for edges en_lo..en_hi, config
  // is altered at edge chg_at, and an expectation is queued on edge pre-1.
  task automatic drive_bit(input int pre, input int len, input logic [1:0] mode,
                           input logic [31:0] pat, input int en_lo, input int en_hi,
                           input int chg_at, input int chg_pre,
                           input logic expv, input logic eb, input logic exn);
    prescale  = 6'(pre);
    samp_mode = mode;
    for (int e = 0; e < len; e++) begin
      edge_cnt     = 5'(e);
      rx_in        = pat[e];
      data_samp_en = (e >= en_lo) && (e <= en_hi);
      if (e == chg_at) begin
        prescale  = 6'(chg_pre);
        samp_mode = 2'd2;
      end
      if (expv && e == pre - 1) exp_q.push_back('{eb, exn, cyc + 1});
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    prescale     = 6'd8;
    samp_mode    = 2'd1;
    rx_in        = 1'b0;
    data_samp_en = 1'b0;
    edge_cnt     = '0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sampled_bit !== 1'b1) begin
      n_bad++; $display("FAIL reset_bit: got %b, required 1", sampled_bit);
    end
    n_cmp++;
    if (sampled_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b, required 0", sampled_valid);
    end
    n_cmp++;
    if (noise_flag !== 1'b0) begin
      n_bad++; $display("FAIL reset_noise: got %b, required 0", noise_flag);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_p8_unanimous;
    drive_bit(8, 8, 2'd1, 32'h0000_0038, 0, 7, -1, 0, 1'b1, 1'b1, 1'b0);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL p8_pending: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_p16_noisy;
    // 0 at 6 and 10, 1 at 7..9, ones outside the window on the low side.
    drive_bit(16, 16, 2'd2, 32'h0000_03BF, 0, 15, -1, 0, 1'b1, 1'b1, 1'b1);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL p16_pending: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_p4_clamp;
    // Edges 0..3 = 1,0,0,1: window 1..3 gives one vote of three.
    drive_bit(4, 4, 2'd2, 32'h0000_0009, 0, 3, -1, 0, 1'b1, 1'b0, 1'b1);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL p4_pending: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_p32_cfg_change;
    drive_bit(32, 32, 2'd0, 32'hFFFE_FFFF, 0, 31, 20, 8, 1'b1, 1'b0, 1'b0);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL p32_pending: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_edges;
    // Late enable: no strobe for this bit.
    drive_bit(8, 8, 2'd1, 32'hFFFF_FFFF, 5, 7, -1, 0, 1'b0, 1'b0, 1'b0);
    // Next bit from edge 0: one vote of three.
    drive_bit(8, 8, 2'd1, 32'h0000_0008, 0, 7, -1, 0, 1'b1, 1'b0, 1'b1);
    // Enable dropped at edge 4: no strobe, outputs hold.
    drive_bit(8, 8, 2'd1, 32'hFFFF_FFFF, 0, 3, -1, 0, 1'b0, 1'b0, 1'b0);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL enable_pending: %0d outstanding, required 0", exp_q.size());
    end
    n_cmp++;
    if (sampled_bit !== 1'b0 || noise_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_hold: bit=%b noise=%b, required bit=0 noise=1", sampled_bit, noise_flag);
    end
  endtask

  task automatic test_async_reset;
    prescale     = 6'd8;
    samp_mode    = 2'd1;
    data_samp_en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      edge_cnt = 5'(e);
      rx_in    = 1'b0;
      @(negedge clk);
    end
    edge_cnt = 5'd4;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (sampled_bit !== 1'b1 || sampled_valid !== 1'b0 || noise_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: bit=%b valid=%b noise=%b, required 1 0 0",
               sampled_bit, sampled_valid, noise_flag);
    end
    @(negedge clk);
    data_samp_en = 1'b0;
    edge_cnt     = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sampled_bit !== 1'b1 || sampled_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: bit=%b valid=%b, required bit=1 valid=0", sampled_bit, sampled_valid);
    end
  endtask

  task automatic test_illegal_prescale;
    drive_bit(12, 12, 2'd1, 32'h0000_0000, 0, 11, -1, 0, 1'b0, 1'b0, 1'b0);
    drive_bit(12, 12, 2'd0, 32'h0000_0000, 0, 11, -1, 0, 1'b0, 1'b0, 1'b0);
    data_samp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL illegal_pending: %0d outstanding, required 0", exp_q.size());
    end
    n_cmp++;
    if (sampled_bit !== 1'b1 || noise_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_hold: bit=%b noise=%b, required bit=1 noise=0", sampled_bit, noise_flag);
    end
  endtask

  task automatic test_back_to_back;
    int pres[4];
    pres = '{4, 8, 16, 32};
    for (int k = 0; k < 24; k++) begin
      int          p;
      int          nv;
      int          c;
      int          ones;
      logic [1:0]  m;
      logic [31:0] pat;
      logic        eb;
      logic        enz;
      p   = pres[$urandom_range(0, 3)];
      m   = 2'($urandom_range(0, 3));
      pat = $urandom();
      nv  = (m == 2'd0) ? 1 : (m == 2'd2) ? 5 : 3;
      if (p == 4 && nv == 5) nv = 3;
      c    = p / 2;
      ones = 0;
      for (int e = c - (nv - 1) / 2; e <= c + (nv - 1) / 2; e++) begin
        if (pat[e]) ones++;
      end
      eb  = (2 * ones > nv);
      enz = (ones != 0) && (ones != nv);
      drive_bit(p, p, m, pat, 0, p - 1, -1, 0, 1'b1, eb, enz);
    end
    data_samp_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_pending: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_p8_unanimous;
    test_p16_noisy;
    test_p4_clamp;
    test_p32_cfg_change;
    test_enable_edges;
    test_async_reset;
    test_illegal_prescale;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
